rpn_stack_engine: RTL

- Operand stack and ALU for the RPN calculator.
- Sits between the button front-end (synchroniser, debounce, falling-edge detect) and the display path.
- Accepts one-cycle command pulses and an 8-bit two's-complement entry value. Maintains a LIFO operand stack with add, subtract and multi-cycle multiply.
- Presents top-of-stack and status to the signed-decimal/hex display drivers and LEDs.

---
 rtl/rpn_pkg.sv | 27 ++
 rtl/rpn_stack_engine_mult.sv | 62 ++++++
 rtl/rpn_stack_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared types and saturation helpers for the RPN stack engine.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WB
    } state_t;

    function automatic longint satMax(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint satMin(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/rpn_stack_engine_mult.sv
// Iterative shift-add signed multiplier: WIDTH cycles per product, sign applied to magnitudes.
module rpn_seq_mult
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int NW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [NW-1:0]      r_cnt;
    logic               r_active;
    logic               r_neg;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;

    // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    assign w_magA = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_magB = i_b[WIDTH-1] ? -i_b : i_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_neg    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_magA};
            r_mplier <= w_magB;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
        end else if (r_active) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + NW'(1);
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done    = r_active && (r_cnt == NW'(WIDTH - 1));
    assign o_product = r_neg ? -r_acc : r_acc;

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN operand stack with add/sub and a sequenced multiply.
// Define RPN_SAT_ARITH_EN to saturate arithmetic results instead of wrapping.
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_value_in,
    input  logic                     i_push_p,
    input  logic                     i_pop_p,
    input  logic                     i_add_p,
    input  logic                     i_sub_p,
    input  logic                     i_mul_p,
    output logic [WIDTH-1:0]         o_top,
    output logic                     o_top_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_stack [DEPTH];
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_top;
    logic               r_top_valid;
    logic               r_busy;
    logic               r_err;
    state_t             r_state;

    state_t             w_stateNext;
    op_t                w_op;
    logic [CW-1:0]      w_cntM1;
    logic [CW-1:0]      w_cntM2;
    logic [CW-1:0]      w_countNext;
    logic [CW-1:0]      w_newTopIdx;
    logic [CW-1:0]      w_wrIdx;
    logic [WIDTH-1:0]   w_wrData;
    logic [WIDTH-1:0]   w_opTop;
    logic [WIDTH-1:0]   w_opNext;
    logic [WIDTH-1:0]   w_addRes;
    logic [WIDTH-1:0]   w_subRes;
    logic [WIDTH-1:0]   w_mulRes;
    logic [WIDTH-1:0]   w_topNext;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_wrEn;
    logic               w_errNext;
    logic               w_start;
    logic               w_mulDone;

    assign w_cntM1     = r_count - CW'(1);
    assign w_cntM2     = r_count - CW'(2);
    assign w_newTopIdx = w_countNext - CW'(1);

    rpn_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (w_start),
        .i_a       (w_opNext),
        .i_b       (w_opTop),
        .o_done    (w_mulDone),
        .o_product (w_prod)
    );

    // Out-of-range indices (count below 2) simply select zero; those commands are rejected anyway.
    always_comb begin
        w_opTop  = '0;
        w_opNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == w_cntM1) w_opTop  = r_stack[i];
            if (CW'(i) == w_cntM2) w_opNext = r_stack[i];
        end
    end

`ifdef RPN_SAT_ARITH_EN
    localparam logic signed [2*WIDTH-1:0] P_MAX = (2*WIDTH)'(satMax(WIDTH));
    localparam logic signed [2*WIDTH-1:0] P_MIN = (2*WIDTH)'(satMin(WIDTH));
    localparam logic [WIDTH-1:0]          S_MAX = WIDTH'(satMax(WIDTH));
    localparam logic [WIDTH-1:0]          S_MIN = WIDTH'(satMin(WIDTH));

    logic [WIDTH:0] w_sumExt;
    logic [WIDTH:0] w_diffExt;

    assign w_sumExt  = {w_opNext[WIDTH-1], w_opNext} + {w_opTop[WIDTH-1], w_opTop};
    assign w_diffExt = {w_opNext[WIDTH-1], w_opNext} - {w_opTop[WIDTH-1], w_opTop};
    assign w_addRes  = (w_sumExt[WIDTH] != w_sumExt[WIDTH-1])
                     ? (w_sumExt[WIDTH] ? S_MIN : S_MAX) : w_sumExt[WIDTH-1:0];
    assign w_subRes  = (w_diffExt[WIDTH] != w_diffExt[WIDTH-1])
                     ? (w_diffExt[WIDTH] ? S_MIN : S_MAX) : w_diffExt[WIDTH-1:0];
    assign w_mulRes  = ($signed(w_prod) > P_MAX) ? S_MAX
                     : ($signed(w_prod) < P_MIN) ? S_MIN : w_prod[WIDTH-1:0];
`else
    logic w_unusedProdHi;

    assign w_addRes       = w_opNext + w_opTop;
    assign w_subRes       = w_opNext - w_opTop;
    assign w_mulRes       = w_prod[WIDTH-1:0];
    assign w_unusedProdHi = ^w_prod[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        w_op = OP_NONE;
        if (r_state == IDLE) begin
            if (i_push_p)     w_op = OP_PUSH;
            else if (i_pop_p) w_op = OP_POP;
            else if (i_add_p) w_op = OP_ADD;
            else if (i_sub_p) w_op = OP_SUB;
            else if (i_mul_p) w_op = OP_MUL;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_errNext   = r_err;
        w_wrEn      = 1'b0;
        w_wrIdx     = r_count;
        w_wrData    = i_value_in;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                case (w_op)
                    OP_PUSH: begin
                        if (r_count < CW'(DEPTH)) begin
                            w_wrEn      = 1'b1;
                            w_countNext = r_count + CW'(1);
                            w_errNext   = 1'b0;
                        end else begin
                            w_errNext = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (r_count != '0) begin
                            w_countNext = w_cntM1;
                            w_errNext   = 1'b0;
                        end else begin
                            w_errNext = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (r_count >= CW'(2)) begin
                            w_wrEn      = 1'b1;
                            w_wrIdx     = w_cntM2;
                            w_wrData    = (w_op == OP_ADD) ? w_addRes : w_subRes;
                            w_countNext = w_cntM1;
                            w_errNext   = 1'b0;
                        end else begin
                            w_errNext = 1'b1;
                        end
                    end
                    OP_MUL: begin
                        if (r_count >= CW'(2)) begin
                            w_start     = 1'b1;
                            w_stateNext = MUL;
                        end else begin
                            w_errNext = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            MUL: begin
                if (w_mulDone) w_stateNext = WB;
            end
            WB: begin
                w_wrEn      = 1'b1;
                w_wrIdx     = w_cntM2;
                w_wrData    = w_mulRes;
                w_countNext = w_cntM1;
                w_errNext   = 1'b0;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // The new top is either the slot being written this cycle or an existing entry.
    always_comb begin
        w_topNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == w_newTopIdx) w_topNext = r_stack[i];
        end
        if (w_wrEn && (w_wrIdx == w_newTopIdx)) w_topNext = w_wrData;
        if (w_countNext == '0) w_topNext = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_top       <= '0;
            r_top_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_count     <= w_countNext;
            r_top       <= w_topNext;
            r_top_valid <= (w_countNext != '0);
            r_busy      <= (w_stateNext != IDLE);
            r_err       <= w_errNext;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wrEn && (w_wrIdx == CW'(i))) r_stack[i] <= w_wrData;
        end
    end

    assign o_top       = r_top;
    assign o_top_valid = r_top_valid;
    assign o_count     = r_count;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule
